// File: rtl/mult_share_sched.sv
// Shares one signed WxW multiplier among up to four MAC lanes per sample period.
// Define MULT_SHARE_RR_EN for round-robin arbitration; fixed priority otherwise.
module mult_share_sched #(
  parameter int NREQ = 4,
  parameter int W    = 18
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              sam_clk_ena,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_in,
  input  logic [NREQ*W-1:0] b_in,
  output logic [NREQ-1:0]   gnt,
  output logic [2*W-1:0]    rslt,
  output logic              rslt_vld,
  output logic [1:0]        rslt_id,
  output logic [1:0]        slot,
  output logic              overrun
);

  logic [NREQ-1:0] served_q;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] gnt_c;
  logic [1:0]      gnt_idx;
  logic            gnt_any;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;

  logic [W-1:0]    s1_a;
  logic [W-1:0]    s1_b;
  logic [1:0]      s1_id;
  logic            s1_vld;
  logic signed [2*W-1:0] prod;

  assign elig = req & ~served_q;

`ifdef MULT_SHARE_RR_EN
  logic [1:0] rr_ptr;

  // Scan eligible lanes starting at the pointer, wrapping modulo NREQ.
  always_comb begin
    logic found;
    int   idx;
    gnt_c = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && elig[idx]) begin
        gnt_c[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      rr_ptr <= 2'd0;
    end else if (gnt_any) begin
      if (gnt_idx == 2'(NREQ - 1))
        rr_ptr <= 2'd0;
      else
        rr_ptr <= gnt_idx + 2'd1;
    end
  end
`else
  always_comb begin
    logic found;
    gnt_c = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && elig[k]) begin
        gnt_c[k] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

  assign gnt     = reset ? '0 : gnt_c;
  assign gnt_any = |gnt;

  always_comb begin
    gnt_idx = 2'd0;
    sel_a   = '0;
    sel_b   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gnt_idx = 2'(i);
        sel_a   = a_in[i*W +: W];
        sel_b   = b_in[i*W +: W];
      end
    end
  end

  assign prod = $signed(s1_a) * $signed(s1_b);

  // Slot counter re-aligns to the strobe; mask clears as the new period starts.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      slot     <= 2'd0;
      served_q <= '0;
      overrun  <= 1'b0;
    end else begin
      slot     <= sam_clk_ena ? 2'd0 : slot + 2'd1;
      served_q <= sam_clk_ena ? '0 : (served_q | gnt);
      overrun  <= sam_clk_ena & (|(elig & ~gnt));
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= 2'd0;
      s1_vld   <= 1'b0;
      rslt     <= '0;
      rslt_id  <= 2'd0;
      rslt_vld <= 1'b0;
    end else begin
      s1_vld   <= gnt_any;
      rslt_vld <= s1_vld;
      if (gnt_any) begin
        s1_a  <= sel_a;
        s1_b  <= sel_b;
        s1_id <= gnt_idx;
      end
      if (s1_vld) begin
        rslt    <= prod;
        rslt_id <= s1_id;
      end
    end
  end

endmodule

// File: doc/mult_share_sched.md
# mult_share_sched

Time-multiplexed scheduler that shares one signed W×W hardware multiplier among up to four requesters (pulse-shaping and matched-filter MAC lanes) inside each sample period. It runs on the 25 MHz system clock. The period is framed by the sample-rate enable from the clock generator, which gives four system-clock slots per sample. The block arbitrates requests, captures the granted operands, and returns a tagged full-precision product with fixed latency.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..4)
- W, 18, operand width, signed two's complement

Ports:
- sys_clk  in  1  system clock, 25 MHz; all logic on rising edge
- reset  in  1  synchronous, active-high
- sam_clk_ena  in  1  one-cycle strobe in the last slot of each sample period (every 4th cycle)
- req  in  NREQ  per-requester request, level; held until granted
- a_in  in  NREQ*W  packed operand A; lane i at [i*W +: W]
- b_in  in  NREQ*W  packed operand B; lane i at [i*W +: W]
- gnt  out  NREQ  one-hot grant, combinational, at most one bit high
- rslt  out  2W  signed product, registered
- rslt_vld  out  1  rslt valid, one-cycle pulse per product
- rslt_id  out  2  index of requester that owns rslt
- slot  out  2  current slot within sample period, 0..3
- overrun  out  1  one-cycle pulse: a request went unserved in a period

## Operation
- Slot counter: increments every cycle, 3→0 wrap. On a cycle with sam_clk_ena=1, next slot=0. The counter therefore re-aligns to the strobe whenever the two disagree.
- Served mask (NREQ bits): bit i set when lane i is granted. The whole mask clears on the cycle after sam_clk_ena, so each lane gets at most one grant per sample period.
- Eligible lanes: req[i]=1 and served[i]=0. At most one grant per cycle.
- Arbitration (see Configuration): the winner gets gnt[i]=1 in the same cycle. a_in/b_in of that lane are registered at that edge.
- Requester rule: the requester may drop req in the cycle after gnt. A req still high after service is ignored until the mask clears.
- Pipeline: stage 1 registers operands and id. Stage 2 registers the product and drives rslt, rslt_id and rslt_vld.
- Arithmetic: full-precision signed W×W→2W, with no rounding or saturation. (−2^(W−1))² = 2^(2W−2) is representable.
- Overrun: if in a sam_clk_ena cycle any eligible lane is not granted, overrun pulses high on the next cycle. The lane stays pending and is served in the next period.
- gnt is forced to 0 while reset=1.

## Timing
- Reset values: gnt=0, rslt=0, rslt_vld=0, rslt_id=0, slot=0, overrun=0, served=0, RR pointer=0.
- Latency: gnt in cycle N → rslt_vld=1 in cycle N+2. Throughput is one product per cycle.
- Reset mid-operation: in-flight stage-1/stage-2 data are discarded. Outputs take their reset values at the first edge with reset=1, with no spurious rslt_vld after deassertion.
- Grant in the sam_clk_ena cycle itself is allowed and counts toward the ending period; that lane's mask bit is then cleared by the period clear.
- req asserted in the cycle of the mask clear is eligible in that same cycle.

## Configuration
- MULT_SHARE_RR_EN defined: round-robin arbitration. The pointer moves to (granted index + 1) mod NREQ on each grant, and eligible lanes are searched starting at the pointer.
- MULT_SHARE_RR_EN undefined: fixed priority, lowest eligible index wins, and the pointer logic is removed. Every other behaviour is identical.

## Test plan
- Single lane: req[2]=1 with a=3, b=−5 at slot 0 → gnt=4'b0100 in the same cycle; 2 cycles later rslt=−15, rslt_id=2, rslt_vld one cycle.
- All four lanes request at period start, with RR enabled and pointer=0 → grants 0,1,2,3 in slots 0..3; four consecutive rslt_vld; overrun=0.
- req[1] held high for two periods → exactly one grant per period; no re-grant before the mask clear.
- Corner product: a=b=−131072 (W=18) → rslt=2^34, positive, no overflow.
- Overrun with fixed priority: lane 0 is granted at slot 3 of the previous period, so it is already served when the new period clears the mask. In the new period, lanes 0..3 all request at slot 1 → lanes 0, 1 and 2 are granted in slots 1, 2 and 3. Lane 3 is still unserved at the sam_clk_ena cycle (slot 3), so overrun pulses in the next cycle, and lane 3 is granted at slot 0 of the following period.
- Reset asserted one cycle after a grant → no rslt_vld; all outputs 0; normal grants resume after reset deasserts.
